// File: rtl/ps2_key_rx_if.sv
// PS/2 pin and key-word bundle between a PS/2 source (pins or bench model) and the receiver.
interface ps2_key_rx_if;
  logic        ps2_clk_i;
  logic        ps2_dat_i;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (output ps2_clk_i, ps2_dat_i, input ps2_key, frame_err, busy);
  modport slave  (input ps2_clk_i, ps2_dat_i, output ps2_key, frame_err, busy);
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver producing the toggle-encoded 11-bit ps2_key word
// {toggle, pressed, extended, scancode} in the clk_sys domain.
module ps2_key_rx #(
  parameter int FILTER      = 8,
  parameter int TIMEOUT_CYC = 4800
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  ps2_key_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]        r_clk_s, r_dat_s;
  logic [FW-1:0]     r_fcnt;
  logic              r_clk_f, r_clk_fd;
  logic [FILTER-1:0] r_dat_d;
  logic              w_fall, w_dat;

  logic [1:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_sr;
  logic              r_par_ok;
  logic [TW-1:0]     r_tcnt;
  logic              r_err, r_byte_vld;

  logic              r_ext, r_rel;
  logic [2:0]        r_skip;
  logic [10:0]       r_key;

  // Synchronize, debounce clock, and delay data by the filter depth so it
  // lines up with the filtered clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_fcnt   <= '0;
      r_clk_f  <= 1'b1;
      r_clk_fd <= 1'b1;
      r_dat_d  <= '1;
    end else begin
      r_clk_s  <= {r_clk_s[0], bus.ps2_clk_i};
      r_dat_s  <= {r_dat_s[0], bus.ps2_dat_i};
      r_clk_fd <= r_clk_f;
      r_dat_d  <= {r_dat_d[FILTER-2:0], r_dat_s[1]};
      if (r_clk_s[1] == r_clk_f) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER - 1)) begin
        r_clk_f <= r_clk_s[1];
        r_fcnt  <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_fall = r_clk_fd & ~r_clk_f;
  assign w_dat  = r_dat_d[FILTER-1];

  // Frame FSM: one transition per filtered falling edge, plus inactivity timeout.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_sr       <= '0;
      r_par_ok   <= 1'b0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_byte_vld <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_byte_vld <= 1'b0;
      if (r_state != S_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_tcnt  <= '0;
      end else if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          S_IDLE: if (!w_dat) begin
            r_state  <= S_DATA;
            r_bitcnt <= '0;
          end
          S_DATA: begin
            r_sr     <= {w_dat, r_sr[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PAR;
          end
          S_PAR: begin
            r_par_ok <= (^r_sr) ^ w_dat;
            r_state  <= S_STOP;
          end
          default: begin
            if (w_dat && r_par_ok) r_byte_vld <= 1'b1;
            else                   r_err      <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        r_tcnt <= r_tcnt + TW'(1);
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  // Byte decode; sr is stable here because the next frame cannot shift data
  // until its first data bit, many cycles after the start bit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
      r_key  <= '0;
    end else if (r_err) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
    end else if (r_byte_vld) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (r_sr == 8'hE1) begin
        r_skip <= 3'd7;
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
      end else if (r_sr == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_sr == 8'hF0) begin
        r_rel <= 1'b1;
      end else begin
        r_key <= {~r_key[10], ~r_rel, r_ext, r_sr};
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign bus.ps2_key   = r_key;
  assign bus.frame_err = r_err;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: a PS/2 device model drives frames, expected key
// words go to a scoreboard queue and are popped whenever ps2_key changes.
module tb_ps2_key_rx;
  localparam int TO    = 4800;
  localparam int SLOW  = 960;  // half bit period at 80 us
  localparam int FAST  = 48;

  logic clk, rst_n;
  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER(8), .TIMEOUT_CYC(TO)) dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #21 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  bit mon_en = 1'b0;
  bit busy_hi = 1'b0;
  logic [10:0] prev_key = '0;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int h);
    @(negedge clk);
    bus.ps2_dat_i = b;
    wait_cyc(h / 2);
    bus.ps2_clk_i = 1'b0;
    wait_cyc(h);
    bus.ps2_clk_i = 1'b1;
    wait_cyc(h / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits, input int h);
    ps2_bit(1'b0, h);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], h);
    if (nbits == 8) begin
      ps2_bit((~^b) ^ flip_par, h);
      ps2_bit(1'b1, h);
    end
    bus.ps2_dat_i = 1'b1;
    wait_cyc(60);
  endtask

  // Scoreboard monitor: every ps2_key change must match the next queued word.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.ps2_key !== prev_key) begin
          if (exp_q.size() == 0) chk("unexpected_update", 32'(bus.ps2_key), 32'(prev_key));
          else                   chk("key_word", 32'(bus.ps2_key), 32'(exp_q.pop_front()));
          prev_key = bus.ps2_key;
        end
        if (bus.frame_err) err_cnt++;
        if (bus.busy) busy_hi = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] pause_seq [8];
    int n;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    bus.ps2_clk_i = 1'b1;
    bus.ps2_dat_i = 1'b1;
    rst_n = 1'b0;
    wait_cyc(5);
    chk("reset_key", 32'(bus.ps2_key), 32'h0);
    chk("reset_err", 32'(bus.frame_err), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);
    mon_en = 1'b1;

    // 3-cycle clock glitch with data low must not start a frame
    bus.ps2_dat_i = 1'b0;
    bus.ps2_clk_i = 1'b0;
    wait_cyc(3);
    bus.ps2_clk_i = 1'b1;
    wait_cyc(30);
    bus.ps2_dat_i = 1'b1;
    wait_cyc(30);
    chk("glitch_busy_seen", 32'(busy_hi), 32'h0);
    chk("glitch_err", 32'(err_cnt), 32'h0);

    // 0x1C make code at 80 us bit period
    exp_q.push_back(11'h61C);
    busy_hi = 1'b0;
    send_frame(8'h1C, 1'b0, 8, SLOW);
    chk("f1c_busy_during", 32'(busy_hi), 32'h1);
    chk("f1c_busy_after", 32'(bus.busy), 32'h0);
    chk("f1c_err", 32'(err_cnt), 32'h0);
    chk("f1c_key", 32'(bus.ps2_key), 32'h61C);

    // break, extended make, extended break
    send_frame(8'hF0, 1'b0, 8, FAST);
    exp_q.push_back(11'h01C);
    send_frame(8'h1C, 1'b0, 8, FAST);
    chk("break_1c", 32'(bus.ps2_key), 32'h01C);
    send_frame(8'hE0, 1'b0, 8, FAST);
    exp_q.push_back(11'h775);
    send_frame(8'h75, 1'b0, 8, FAST);
    chk("ext_make_75", 32'(bus.ps2_key), 32'h775);
    send_frame(8'hE0, 1'b0, 8, FAST);
    send_frame(8'hF0, 1'b0, 8, FAST);
    chk("prefix_no_update", 32'(bus.ps2_key), 32'h775);
    exp_q.push_back(11'h175);
    send_frame(8'h75, 1'b0, 8, FAST);
    chk("ext_break_75", 32'(bus.ps2_key), 32'h175);

    // parity error then good frame
    send_frame(8'h29, 1'b1, 8, FAST);
    chk("par_err_count", 32'(err_cnt), 32'h1);
    chk("par_err_key_held", 32'(bus.ps2_key), 32'h175);
    exp_q.push_back(11'h629);
    send_frame(8'h29, 1'b0, 8, FAST);
    chk("good_29", 32'(bus.ps2_key), 32'h629);

    // timeout mid-frame after an E0 prefix
    send_frame(8'hE0, 1'b0, 8, FAST);
    send_frame(8'h6B, 1'b0, 4, FAST);
    chk("timeout_busy_mid", 32'(bus.busy), 32'h1);
    n = 0;
    while (bus.busy && n < TO + 300) begin
      @(negedge clk);
      n++;
    end
    wait_cyc(2);
    chk("timeout_busy_clear", 32'(bus.busy), 32'h0);
    chk("timeout_err_count", 32'(err_cnt), 32'h2);
    exp_q.push_back(11'h26B);
    send_frame(8'h6B, 1'b0, 8, FAST);
    chk("after_timeout_6b", 32'(bus.ps2_key), 32'h26B);

    // Pause sequence swallowed, next key decodes normally
    foreach (pause_seq[i]) send_frame(pause_seq[i], 1'b0, 8, FAST);
    chk("pause_key_held", 32'(bus.ps2_key), 32'h26B);
    exp_q.push_back(11'h616);
    send_frame(8'h16, 1'b0, 8, FAST);
    chk("after_pause_16", 32'(bus.ps2_key), 32'h616);
    chk("no_extra_err", 32'(err_cnt), 32'h2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // reset mid-frame
    ps2_bit(1'b0, FAST);
    ps2_bit(1'b1, FAST);
    ps2_bit(1'b0, FAST);
    chk("midframe_busy", 32'(bus.busy), 32'h1);
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_key", 32'(bus.ps2_key), 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_err", 32'(bus.frame_err), 32'h0);
    bus.ps2_dat_i = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
